// File: rtl/stack_arbiter.sv
// Round-robin controller sharing one LIFO stack between two requesters.
// Blocks overflow/underflow and returns per-requester responses.
module stack_arbiter #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned STACK_SIZE = 4,
  parameter int unsigned CNT_W      = $clog2(STACK_SIZE + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  req0_valid,
  input  logic                  req0_op,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  output logic                  req0_ready,
  output logic                  rsp0_valid,
  output logic [DATA_WIDTH-1:0] rsp0_rdata,
  output logic                  rsp0_err,
  input  logic                  req1_valid,
  input  logic                  req1_op,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic                  req1_ready,
  output logic                  rsp1_valid,
  output logic [DATA_WIDTH-1:0] rsp1_rdata,
  output logic                  rsp1_err,
  output logic                  stk_rst,
  output logic                  stk_push,
  output logic                  stk_pop,
  output logic [DATA_WIDTH-1:0] stk_wdata,
  input  logic [DATA_WIDTH-1:0] stk_rdata,
  output logic [CNT_W-1:0]      count,
  output logic                  full,
  output logic                  empty
);

  typedef enum logic [2:0] {INIT, IDLE, ISSUE, WAIT, RESP, FLUSH} state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        count_d;
  logic                    full_d, empty_d;
  logic                    last_grant_q, last_grant_d;
  logic                    id_q, id_d;
  logic                    grant;
  logic                    op_sel;
  logic [DATA_WIDTH-1:0]   wdata_sel;
  logic                    stk_rst_d, stk_push_d, stk_pop_d;
  logic [DATA_WIDTH-1:0]   stk_wdata_d;
  logic                    rsp_valid_d, rsp_err_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_d;

  // Strobes and responses are computed one cycle ahead so the registered
  // outputs line up with the state they belong to.
  always_comb begin
    state_d      = state_q;
    count_d      = count;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    stk_rst_d    = 1'b0;
    stk_push_d   = 1'b0;
    stk_pop_d    = 1'b0;
    stk_wdata_d  = '0;
    rsp_valid_d  = 1'b0;
    rsp_err_d    = 1'b0;
    rsp_rdata_d  = '0;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    grant        = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
    op_sel       = grant ? req1_op : req0_op;
    wdata_sel    = grant ? req1_wdata : req0_wdata;

    case (state_q)
      INIT: begin
        stk_rst_d = 1'b1;
        state_d   = IDLE;
      end
      IDLE: begin
        if (flush) begin
          stk_rst_d = 1'b1;
          state_d   = FLUSH;
        end else if (req0_valid || req1_valid) begin
          req0_ready   = ~grant;
          req1_ready   = grant;
          id_d         = grant;
          last_grant_d = grant;
          if (!op_sel && !full) begin
            stk_push_d  = 1'b1;
            stk_wdata_d = wdata_sel;
          end
          if (op_sel && !empty) stk_pop_d = 1'b1;
          state_d = ISSUE;
        end
      end
      FLUSH: begin
        count_d = '0;
        state_d = IDLE;
      end
      ISSUE: begin
        if (stk_push) begin
          count_d     = count + CNT_W'(1);
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else if (stk_pop) begin
          count_d = count - CNT_W'(1);
          state_d = WAIT;
        end else begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          state_d     = RESP;
        end
      end
      WAIT: begin
        rsp_valid_d = 1'b1;
        rsp_rdata_d = stk_rdata;
        state_d     = RESP;
      end
      RESP: state_d = IDLE;
      default: state_d = INIT;
    endcase

    full_d  = (count_d == CNT_W'(STACK_SIZE));
    empty_d = (count_d == '0);
  end

  // State, status and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= INIT;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b0;
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
      stk_rst      <= 1'b0;
      stk_push     <= 1'b0;
      stk_pop      <= 1'b0;
      stk_wdata    <= '0;
      rsp0_valid   <= 1'b0;
      rsp0_err     <= 1'b0;
      rsp0_rdata   <= '0;
      rsp1_valid   <= 1'b0;
      rsp1_err     <= 1'b0;
      rsp1_rdata   <= '0;
    end else begin
      state_q      <= state_d;
      count        <= count_d;
      full         <= full_d;
      empty        <= empty_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      stk_rst      <= stk_rst_d;
      stk_push     <= stk_push_d;
      stk_pop      <= stk_pop_d;
      stk_wdata    <= stk_wdata_d;
      rsp0_valid   <= rsp_valid_d & ~id_q;
      rsp0_err     <= rsp_err_d & ~id_q;
      rsp0_rdata   <= id_q ? '0 : rsp_rdata_d;
      rsp1_valid   <= rsp_valid_d & id_q;
      rsp1_err     <= rsp_err_d & id_q;
      rsp1_rdata   <= id_q ? rsp_rdata_d : '0;
    end
  end

endmodule

// File: tb/tb_stack_arbiter.sv
// Directed bench for stack_arbiter with a behavioural LIFO on the stack port.
`timescale 1ns/1ps
module tb_stack_arbiter;

  logic       clk;
  logic       rst;
  logic       flush;
  logic       req0_valid, req0_op, req0_ready, rsp0_valid, rsp0_err;
  logic [7:0] req0_wdata, rsp0_rdata;
  logic       req1_valid, req1_op, req1_ready, rsp1_valid, rsp1_err;
  logic [7:0] req1_wdata, rsp1_rdata;
  logic       stk_rst, stk_push, stk_pop;
  logic [7:0] stk_wdata, stk_rdata;
  logic [2:0] count;
  logic       full, empty;

  int checks = 0;
  int errors = 0;
  int push_cnt = 0;
  int pop_cnt = 0;
  int overlap = 0;
  int rsp1_cnt = 0;

  stack_arbiter #(.DATA_WIDTH(8), .STACK_SIZE(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req0_valid(req0_valid), .req0_op(req0_op), .req0_wdata(req0_wdata),
    .req0_ready(req0_ready), .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
    .rsp0_err(rsp0_err),
    .req1_valid(req1_valid), .req1_op(req1_op), .req1_wdata(req1_wdata),
    .req1_ready(req1_ready), .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .rsp1_err(rsp1_err),
    .stk_rst(stk_rst), .stk_push(stk_push), .stk_pop(stk_pop),
    .stk_wdata(stk_wdata), .stk_rdata(stk_rdata),
    .count(count), .full(full), .empty(empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stack datapath: sync clear, push/pop strobes, registered read data on pop.
  logic [7:0] mem [0:3];
  logic [2:0] sp;
  logic [7:0] rd;
  assign stk_rdata = rd;
  always @(posedge clk) begin
    if (stk_rst) sp <= 3'd0;
    else if (stk_push && sp < 3'd4) begin
      mem[sp[1:0]] <= stk_wdata;
      sp <= sp + 3'd1;
    end else if (stk_pop && sp != 3'd0) begin
      rd <= mem[2'(sp - 3'd1)];
      sp <= sp - 3'd1;
    end
  end

  always @(posedge clk) begin
    if (stk_push) push_cnt <= push_cnt + 1;
    if (stk_pop) pop_cnt <= pop_cnt + 1;
    if (stk_push && stk_pop) overlap <= overlap + 1;
    if (rsp1_valid) rsp1_cnt <= rsp1_cnt + 1;
  end

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // One single-requester transaction: handshake, latency and response checks.
  task automatic do_req(input bit id, input bit op, input logic [7:0] wd,
                        input logic [7:0] exp_rd, input bit exp_err,
                        input int exp_cnt, input string tag);
    int n;
    bit got;
    int p0, q0, lat;
    @(posedge clk); #1;
    if (id) begin req1_valid = 1'b1; req1_op = op; req1_wdata = wd; end
    else     begin req0_valid = 1'b1; req0_op = op; req0_wdata = wd; end
    n = 0;
    got = 1'b0;
    while (!got && n < 20) begin
      @(negedge clk);
      if ((id ? req1_ready : req0_ready) == 1'b1) got = 1'b1;
      else begin @(posedge clk); #1; n++; end
    end
    check({tag, " ready"}, 32'(got), 32'd1);
    p0 = push_cnt;
    q0 = pop_cnt;
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    lat = (op && !exp_err) ? 3 : 2;
    repeat (lat - 1) @(negedge clk);
    check({tag, " early"}, 32'(id ? rsp1_valid : rsp0_valid), 32'd0);
    @(negedge clk);
    check({tag, " valid"}, 32'(id ? rsp1_valid : rsp0_valid), 32'd1);
    check({tag, " other"}, 32'(id ? rsp0_valid : rsp1_valid), 32'd0);
    check({tag, " rdata"}, 32'(id ? rsp1_rdata : rsp0_rdata), 32'(exp_rd));
    check({tag, " err"}, 32'(id ? rsp1_err : rsp0_err), 32'(exp_err));
    check({tag, " pushes"}, 32'(push_cnt - p0), 32'((!op && !exp_err) ? 1 : 0));
    check({tag, " pops"}, 32'(pop_cnt - q0), 32'((op && !exp_err) ? 1 : 0));
    check({tag, " count"}, 32'(count), 32'(exp_cnt));
    check({tag, " full"}, 32'(full), 32'(exp_cnt == 4));
    check({tag, " empty"}, 32'(empty), 32'(exp_cnt == 0));
  endtask

  initial begin
    int g;
    int r0;
    logic [7:0] pv [0:3];
    pv[0] = 8'h11; pv[1] = 8'h22; pv[2] = 8'h33; pv[3] = 8'h44;
    rst = 1'b0; flush = 1'b0;
    req0_valid = 1'b0; req0_op = 1'b0; req0_wdata = 8'h00;
    req1_valid = 1'b0; req1_op = 1'b0; req1_wdata = 8'h00;

    // Reset state and the single stk_rst pulse after INIT.
    repeat (3) @(negedge clk);
    check("rst count", 32'(count), 32'd0);
    check("rst empty", 32'(empty), 32'd0);
    check("rst stk_rst", 32'(stk_rst), 32'd0);
    check("rst rsp", 32'({rsp0_valid, rsp1_valid, req0_ready, req1_ready}), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("init stk_rst", 32'(stk_rst), 32'd1);
    check("init empty", 32'(empty), 32'd1);
    check("init count", 32'(count), 32'd0);
    @(negedge clk);
    check("init stk_rst once", 32'(stk_rst), 32'd0);
    check("idle ready", 32'({req0_ready, req1_ready, rsp0_valid, rsp1_valid}), 32'd0);

    // Fill to full, then overflow.
    for (int i = 0; i < 4; i++) do_req(1'b0, 1'b0, pv[i], 8'h00, 1'b0, i + 1, "push");
    do_req(1'b0, 1'b0, 8'h55, 8'h00, 1'b1, 4, "overflow");

    // Drain in LIFO order, then underflow.
    for (int i = 0; i < 4; i++) do_req(1'b1, 1'b1, 8'h00, pv[3 - i], 1'b0, 3 - i, "pop");
    do_req(1'b1, 1'b1, 8'h00, 8'h00, 1'b1, 0, "underflow");

    // Flush beats a pending request.
    for (int i = 0; i < 3; i++) do_req(1'b0, 1'b0, 8'(8'h61 + i), 8'h00, 1'b0, i + 1, "t5 push");
    @(posedge clk); #1;
    flush = 1'b1; req0_valid = 1'b1; req0_op = 1'b0; req0_wdata = 8'h77;
    @(negedge clk);
    check("flush no ready", 32'(req0_ready), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check("flush stk_rst", 32'(stk_rst), 32'd1);
    check("flush ready", 32'(req0_ready), 32'd0);
    @(negedge clk);
    check("post flush count", 32'(count), 32'd0);
    check("post flush grant", 32'(req0_ready), 32'd1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("post flush rsp", 32'(rsp0_valid), 32'd1);
    check("post flush count1", 32'(count), 32'd1);

    // Reset during WAIT aborts the pop and INIT re-clears the stack.
    do_req(1'b0, 1'b0, 8'h5A, 8'h00, 1'b0, 2, "t6 push");
    r0 = rsp1_cnt;
    @(posedge clk); #1;
    req1_valid = 1'b1; req1_op = 1'b1;
    @(negedge clk);
    check("t6 ready", 32'(req1_ready), 32'd1);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("t6 rst count", 32'(count), 32'd0);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    check("t6 no rsp", 32'(rsp1_cnt - r0), 32'd0);
    check("t6 stack cleared", 32'(sp), 32'd0);
    do_req(1'b1, 1'b1, 8'h00, 8'h00, 1'b1, 0, "t6 pop");

    // Both requesters continuously valid from reset: grants alternate.
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    req0_valid = 1'b1; req0_op = 1'b0; req0_wdata = 8'hA0;
    req1_valid = 1'b1; req1_op = 1'b1;
    rst = 1'b1;
    g = 0;
    for (int c = 0; c < 80 && g < 6; c++) begin
      @(negedge clk);
      if (req0_ready || req1_ready) begin
        check("rr grant", 32'(req1_ready), 32'(g % 2));
        check("rr onehot", 32'(req0_ready & req1_ready), 32'd0);
        g++;
      end
      if (rsp1_valid) begin
        check("rr pop data", 32'(rsp1_rdata), 32'hA0);
        check("rr pop err", 32'(rsp1_err), 32'd0);
      end
      if (rsp0_valid) check("rr push err", 32'(rsp0_err), 32'd0);
    end
    check("rr grants", 32'(g), 32'd6);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("rr count", 32'(count), 32'd0);
    check("rr empty", 32'(empty), 32'd1);
    check("strobe overlap", 32'(overlap), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
